// File: rtl/qcs_nhtp_rd_resp.sv
// rtl/qcs_nhtp_rd_resp.sv - NHTP preamble sample table read responder
// Table read, then puncture/rotation/scaling, then optional delay stages out to the read bus.
module qcs_nhtp_rd_resp #(
  parameter int ADDR_DW   = 8,
  parameter int SAMPLE_W  = 12,
  parameter int BW_W      = 2,
  parameter int SUBBAND_W = 4,
  parameter int GAMMA_W   = 8,
  parameter int RD_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [ADDR_DW-1:0]    cfg_waddr,
  input  logic [2*SAMPLE_W-1:0] cfg_wdata,
  input  logic                  nhtp_re,
  input  logic [ADDR_DW-1:0]    nhtp_raddr,
  input  logic [BW_W-1:0]       txconfig_bw,
  input  logic [BW_W-1:0]       sys_bw_mode,
  input  logic [SUBBAND_W-1:0]  config_mu_subband_present,
  input  logic [GAMMA_W-1:0]    config_gamma_rotation,
  input  logic [3:0]            n_tx,
  input  logic                  nhtp_4ch,
  output logic                  nhtp_rvalid,
  output logic [SAMPLE_W-1:0]   nhtp_rdata_i,
  output logic [SAMPLE_W-1:0]   nhtp_rdata_q,
  output logic [1:0]            nhtp_rsub,
  output logic                  err_oob,
  output logic                  err_cfg
);

  localparam int PW = 4 + 2*SAMPLE_W;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t               state_q;
  logic [BW_W-1:0]      bw_q;
  logic [SUBBAND_W-1:0] present_q;
  logic [GAMMA_W-1:0]   gamma_q;
  logic [3:0]           ntx_q;
  logic                 ch4_q;
  logic                 err_cfg_q;

  logic [2*SAMPLE_W-1:0] mem_q [2**ADDR_DW];
  logic [2*SAMPLE_W-1:0] s1_data_q;
  logic                  s1_valid_q, s1_zero_q, s1_oob_q;
  logic [1:0]            s1_k_q, s1_g_q, s1_sh_q;
  logic [PW-1:0]         pipe_q [RD_LAT-1];
  logic [PW-1:0]         stage2_d;

  // The read that opens a burst uses the live config, which is being latched that same cycle.
  logic                 active;
  logic [BW_W-1:0]      cur_bw;
  logic [SUBBAND_W-1:0] cur_present;
  logic [GAMMA_W-1:0]   cur_gamma;
  logic [3:0]           cur_ntx;
  logic                 cur_4ch, cur_cfg_err;
  logic [1:0]           rk, gcode, sh;
  logic [3:0]           ns;
  logic                 oob;

  assign active      = (state_q == S_ACTIVE);
  assign cur_bw      = active ? bw_q      : txconfig_bw;
  assign cur_present = active ? present_q : config_mu_subband_present;
  assign cur_gamma   = active ? gamma_q   : config_gamma_rotation;
  assign cur_ntx     = active ? ntx_q     : n_tx;
  assign cur_4ch     = active ? ch4_q     : nhtp_4ch;
  assign cur_cfg_err = active ? err_cfg_q : (txconfig_bw > sys_bw_mode);

  assign rk    = nhtp_raddr[ADDR_DW-1 -: 2];
  assign ns    = cur_4ch ? 4'd4 : (4'd1 << cur_bw);
  assign oob   = ({2'b00, rk} >= ns);
  assign gcode = cur_gamma[{rk, 1'b0} +: 2];
  assign sh    = (cur_ntx >= 4'd4) ? 2'd2 : ((cur_ntx >= 4'd2) ? 2'd1 : 2'd0);

  function automatic logic signed [SAMPLE_W-1:0] neg_sat(input logic signed [SAMPLE_W-1:0] x);
    logic signed [SAMPLE_W-1:0] min_v;
    min_v = {1'b1, {(SAMPLE_W-1){1'b0}}};
    return (x == min_v) ? ~min_v : -x;
  endfunction

  // Table has no reset so contents survive a controller reset; read-before-write on collision.
  always_ff @(posedge clk) begin
    if (cfg_we) mem_q[cfg_waddr] <= cfg_wdata;
    s1_data_q <= mem_q[nhtp_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bw_q       <= '0;
      present_q  <= '0;
      gamma_q    <= '0;
      ntx_q      <= '0;
      ch4_q      <= 1'b0;
      err_cfg_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_oob_q   <= 1'b0;
      s1_k_q     <= '0;
      s1_g_q     <= '0;
      s1_sh_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (nhtp_re) begin
          state_q   <= S_ACTIVE;
          bw_q      <= txconfig_bw;
          present_q <= config_mu_subband_present;
          gamma_q   <= config_gamma_rotation;
          ntx_q     <= n_tx;
          ch4_q     <= nhtp_4ch;
          err_cfg_q <= (txconfig_bw > sys_bw_mode);
        end
        default: if (!nhtp_re) state_q <= S_IDLE;
      endcase
      s1_valid_q <= nhtp_re;
      s1_zero_q  <= cur_cfg_err | oob | ~cur_present[rk];
      s1_oob_q   <= oob;
      s1_k_q     <= rk;
      s1_g_q     <= gcode;
      s1_sh_q    <= sh;
    end
  end

  always_comb begin
    logic signed [SAMPLE_W-1:0] di, dq, ri, rq, si, sq;
    di = s1_data_q[2*SAMPLE_W-1:SAMPLE_W];
    dq = s1_data_q[SAMPLE_W-1:0];
    case (s1_g_q)
      2'd0:    begin ri = di;          rq = dq;          end
      2'd1:    begin ri = neg_sat(dq); rq = di;          end
      2'd2:    begin ri = neg_sat(di); rq = neg_sat(dq); end
      default: begin ri = dq;          rq = neg_sat(di); end
    endcase
    si = ri >>> s1_sh_q;
    sq = rq >>> s1_sh_q;
    if (s1_zero_q) begin
      si = '0;
      sq = '0;
    end
    stage2_d = '0;
    if (s1_valid_q) stage2_d = {1'b1, s1_oob_q, s1_k_q, si, sq};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < RD_LAT-1; j++) pipe_q[j] <= '0;
    end else begin
      pipe_q[0] <= stage2_d;
      for (int j = 1; j < RD_LAT-1; j++) pipe_q[j] <= pipe_q[j-1];
    end
  end

  assign {nhtp_rvalid, err_oob, nhtp_rsub, nhtp_rdata_i, nhtp_rdata_q} = pipe_q[RD_LAT-2];
  assign err_cfg = err_cfg_q;

endmodule

// File: tb/tb_qcs_nhtp_rd_resp.sv
// tb/tb_qcs_nhtp_rd_resp.sv - directed scoreboard bench for qcs_nhtp_rd_resp
module tb_qcs_nhtp_rd_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [7:0]  cfg_waddr;
  logic [23:0] cfg_wdata;
  logic        nhtp_re;
  logic [7:0]  nhtp_raddr;
  logic [1:0]  txconfig_bw, sys_bw_mode;
  logic [3:0]  config_mu_subband_present;
  logic [7:0]  config_gamma_rotation;
  logic [3:0]  n_tx;
  logic        nhtp_4ch;
  logic        nhtp_rvalid;
  logic [11:0] nhtp_rdata_i, nhtp_rdata_q;
  logic [1:0]  nhtp_rsub;
  logic        err_oob, err_cfg;

  qcs_nhtp_rd_resp dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .nhtp_re(nhtp_re), .nhtp_raddr(nhtp_raddr), .txconfig_bw(txconfig_bw), .sys_bw_mode(sys_bw_mode),
    .config_mu_subband_present(config_mu_subband_present), .config_gamma_rotation(config_gamma_rotation),
    .n_tx(n_tx), .nhtp_4ch(nhtp_4ch), .nhtp_rvalid(nhtp_rvalid), .nhtp_rdata_i(nhtp_rdata_i),
    .nhtp_rdata_q(nhtp_rdata_q), .nhtp_rsub(nhtp_rsub), .err_oob(err_oob), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] i;
    logic [11:0] q;
    logic [1:0]  s;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == edge_cnt) begin
      e = sb.pop_front();
      check("rvalid", {31'b0, nhtp_rvalid}, 32'd1);
      check("rdata_i", {20'b0, nhtp_rdata_i}, {20'b0, e.i});
      check("rdata_q", {20'b0, nhtp_rdata_q}, {20'b0, e.q});
      check("rsub", {30'b0, nhtp_rsub}, {30'b0, e.s});
      check("err_oob", {31'b0, err_oob}, {31'b0, e.o});
    end else begin
      check("idle_rvalid", {31'b0, nhtp_rvalid}, 32'd0);
      check("idle_out", {8'b0, err_oob, nhtp_rsub, nhtp_rdata_i, nhtp_rdata_q}, 32'd0);
    end
  endtask

  task automatic push(input int ei, input int eq, input int es, input bit eo);
    exp_t e;
    e.due = edge_cnt + 2;
    e.i = 12'(ei);
    e.q = 12'(eq);
    e.s = 2'(es);
    e.o = eo;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [7:0] a, input int wi, input int wq);
    cfg_we = 1'b1; cfg_waddr = a; cfg_wdata = {12'(wi), 12'(wq)};
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input int ei, input int eq, input int es, input bit eo);
    nhtp_re = 1'b1; nhtp_raddr = a;
    push(ei, eq, es, eo);
    tick();
  endtask

  task automatic gap(input int n);
    nhtp_re = 1'b0;
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0; nhtp_re = 1'b0; nhtp_raddr = '0;
    txconfig_bw = 2'd0; sys_bw_mode = 2'd2; config_mu_subband_present = 4'hF;
    config_gamma_rotation = 8'h00; n_tx = 4'd1; nhtp_4ch = 1'b0;
    tick(); tick();
    check("reset_err_cfg", {31'b0, err_cfg}, 32'd0);
    reset = 1'b0;
    tick();

    // T1 basic latency and pass-through
    wr(8'h05, 100, -50);
    rd(8'h05, 100, -50, 0, 1'b0);
    gap(3);

    // T2 rotations on subband 1
    wr(8'h45, 100, -50);
    txconfig_bw = 2'd1; config_gamma_rotation = 8'h04;
    rd(8'h45, 50, 100, 1, 1'b0);
    gap(1);
    config_gamma_rotation = 8'h0C;
    rd(8'h45, -50, -100, 1, 1'b0);
    gap(1);

    // T3 saturating negation and n_tx scaling
    txconfig_bw = 2'd0;
    wr(8'h05, -2048, 0);
    config_gamma_rotation = 8'h02;
    rd(8'h05, 2047, 0, 0, 1'b0);
    gap(1);
    wr(8'h05, 100, -50);
    config_gamma_rotation = 8'h00; n_tx = 4'd4;
    rd(8'h05, 25, -13, 0, 1'b0);
    gap(1);
    n_tx = 4'd0;
    rd(8'h05, 100, -50, 0, 1'b0);
    gap(1);
    n_tx = 4'd2;
    rd(8'h05, 50, -25, 0, 1'b0);
    gap(1);
    n_tx = 4'd1;

    // T4 puncturing, out-of-band, forced 4-subband addressing
    wr(8'h85, 100, -50);
    wr(8'hC5, 100, -50);
    config_mu_subband_present = 4'b1101; txconfig_bw = 2'd2;
    rd(8'h45, 0, 0, 1, 1'b0);
    gap(1);
    txconfig_bw = 2'd0;
    rd(8'h85, 0, 0, 2, 1'b1);
    gap(1);
    nhtp_4ch = 1'b1;
    rd(8'h85, 100, -50, 2, 1'b0);
    gap(1);
    nhtp_4ch = 1'b0; config_mu_subband_present = 4'hF;

    // same-cycle write and read to one address returns the old word
    cfg_we = 1'b1; cfg_waddr = 8'h05; cfg_wdata = {12'd7, 12'd7};
    rd(8'h05, 100, -50, 0, 1'b0);
    cfg_we = 1'b0;
    gap(1);
    rd(8'h05, 7, 7, 0, 1'b0);
    gap(1);
    wr(8'h05, 100, -50);

    // T5 config latched for whole burst
    txconfig_bw = 2'd2; config_gamma_rotation = 8'hE4;
    rd(8'h05, 100, -50, 0, 1'b0);
    rd(8'h45, 50, 100, 1, 1'b0);
    rd(8'h85, -100, 50, 2, 1'b0);
    rd(8'hC5, -50, -100, 3, 1'b0);
    config_gamma_rotation = 8'h00;
    rd(8'h05, 100, -50, 0, 1'b0);
    rd(8'h45, 50, 100, 1, 1'b0);
    rd(8'h85, -100, 50, 2, 1'b0);
    rd(8'hC5, -50, -100, 3, 1'b0);
    gap(2);
    rd(8'h45, 100, -50, 1, 1'b0);
    gap(1);
    sys_bw_mode = 2'd1;
    rd(8'hC5, 0, 0, 3, 1'b0);
    check("err_cfg_set", {31'b0, err_cfg}, 32'd1);
    rd(8'h05, 0, 0, 0, 1'b0);
    gap(1);
    sys_bw_mode = 2'd2;
    rd(8'h05, 100, -50, 0, 1'b0);
    check("err_cfg_clr", {31'b0, err_cfg}, 32'd0);
    gap(2);

    // T6 reset mid-burst drops in-flight reads, keeps table
    txconfig_bw = 2'd0;
    rd(8'h05, 100, -50, 0, 1'b0);
    reset = 1'b1; nhtp_raddr = 8'h05;
    sb.delete();
    tick();
    reset = 1'b0;
    gap(4);
    rd(8'h05, 100, -50, 0, 1'b0);
    gap(3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
